// File: rtl/face_det_pkg.sv
// Shared types and sizing helpers for the frame pixel streamer.
package face_det_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_STREAM    = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_REPORT    = 3'd5
  } state_t;

  localparam int DEF_IMG_WIDTH  = 64;
  localparam int DEF_IMG_HEIGHT = 64;

  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

  // Index width for n items, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FRAME_PIXELS = frame_pixels(DEF_IMG_WIDTH, DEF_IMG_HEIGHT);
  localparam int FRAME_IDX_W  = idx_width(FRAME_PIXELS);

endpackage

// File: rtl/frame_pixel_streamer_if.sv
// Frame RAM read port and face_detector drive/result signals.
//
// Signalling: there is no backpressure anywhere on this bundle.
// mem_rd_en is a read strobe; mem_rd_data is valid exactly one cycle after it.
// pixel_valid qualifies pixel_out for one cycle, the detector must accept it.
// det_start is a one-cycle pulse; det_done is a level, its first high cycle counts.
interface frame_pixel_streamer_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 17
);
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [PIXEL_WIDTH-1:0] mem_rd_data;
  logic                   det_start;
  logic [PIXEL_WIDTH-1:0] pixel_out;
  logic                   pixel_valid;
  logic                   det_face_detected;
  logic [7:0]             det_face_x;
  logic [7:0]             det_face_y;
  logic [7:0]             det_face_scale;
  logic                   det_done;

  modport master (
    output mem_rd_en, mem_addr, det_start, pixel_out, pixel_valid,
    input  mem_rd_data, det_face_detected, det_face_x, det_face_y,
           det_face_scale, det_done
  );

  modport slave (
    input  mem_rd_en, mem_addr, det_start, pixel_out, pixel_valid,
    output mem_rd_data, det_face_detected, det_face_x, det_face_y,
           det_face_scale, det_done
  );
endinterface

// File: rtl/pixel_pacer.sv
// Read-issue pacer: one tick every GAP_CYCLES+1 cycles while enabled,
// the first tick on the first enabled cycle.
module pixel_pacer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(GAP_CYCLES);

  logic [CW-1:0] cnt;

  // Phase counter; held at zero while disabled so enable rising restarts it.
  always_ff @(posedge clk) begin
    if (rst || !enable) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  assign tick = enable && (cnt == '0);
endmodule

// File: rtl/frame_pixel_streamer.sv
// Reads one frame from RAM, streams it to face_detector and latches the result.
module frame_pixel_streamer
  import face_det_pkg::*;
#(
  parameter int IMG_WIDTH      = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT     = DEF_IMG_HEIGHT,
  parameter int PIXEL_WIDTH    = 8,
  parameter int ADDR_WIDTH     = 17,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_req,
  input  logic [ADDR_WIDTH-1:0] frame_base_addr,
  output logic                  busy,
  frame_pixel_streamer_if.master bus,
  output logic                  result_valid,
  output logic                  result_face,
  output logic [7:0]            result_x,
  output logic [7:0]            result_y,
  output logic [7:0]            result_scale,
  output logic                  result_timeout,
  output logic                  result_proto_err,
  output state_t                dbg_state
);
  localparam int N_PIX = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
  localparam int IDX_W = idx_width(N_PIX);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   valid_q;
  logic [PIXEL_WIDTH-1:0] pix_hold_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic                   tick;
  logic                   rd_issue;

  pixel_pacer #(.GAP_CYCLES(GAP_CYCLES)) u_pacer (
    .clk    (clk),
    .rst    (rst),
    .enable (state == ST_STREAM),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and read issue; det_done before the last pixel aborts to REPORT.
  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    case (state)
      ST_IDLE:      if (frame_req) state_nxt = ST_START;
      ST_START:     state_nxt = bus.det_done ? ST_REPORT : ST_STREAM;
      ST_STREAM: begin
        rd_issue = tick;
        if (bus.det_done) state_nxt = ST_REPORT;
        else if (tick && (idx_q == LAST_IDX)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN:     state_nxt = bus.det_done ? ST_REPORT : ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.det_done || (to_cnt_q == TO_LAST)) state_nxt = ST_REPORT;
      ST_REPORT:    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: base/index, pixel valid delay, timeout counter, result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q           <= '0;
      idx_q            <= '0;
      valid_q          <= 1'b0;
      pix_hold_q       <= '0;
      to_cnt_q         <= '0;
      result_face      <= 1'b0;
      result_x         <= '0;
      result_y         <= '0;
      result_scale     <= '0;
      result_timeout   <= 1'b0;
      result_proto_err <= 1'b0;
    end else begin
      // A read issued in an abort cycle never becomes a pixel.
      valid_q    <= rd_issue && ((state_nxt == ST_STREAM) || (state_nxt == ST_DRAIN));
      pix_hold_q <= bus.pixel_out;
      if ((state == ST_IDLE) && frame_req) begin
        base_q <= frame_base_addr;
        idx_q  <= '0;
      end else if (rd_issue) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      to_cnt_q <= (state == ST_WAIT_DONE) ? to_cnt_q + TO_W'(1) : '0;
      if (state_nxt == ST_REPORT) begin
        result_timeout   <= 1'b0;
        result_proto_err <= 1'b0;
        if ((state == ST_WAIT_DONE) && !bus.det_done) begin
          result_face    <= 1'b0;
          result_x       <= '0;
          result_y       <= '0;
          result_scale   <= '0;
          result_timeout <= 1'b1;
        end else begin
          result_face      <= bus.det_face_detected && (state == ST_WAIT_DONE);
          result_x         <= bus.det_face_x;
          result_y         <= bus.det_face_y;
          result_scale     <= bus.det_face_scale;
          result_proto_err <= (state != ST_WAIT_DONE);
        end
      end
    end
  end

  assign bus.mem_rd_en   = rd_issue;
  assign bus.mem_addr    = base_q + ADDR_WIDTH'(idx_q);
  assign bus.det_start   = (state == ST_START);
  assign bus.pixel_valid = valid_q;
  assign bus.pixel_out   = valid_q ? bus.mem_rd_data : pix_hold_q;
  assign busy            = (state != ST_IDLE);
  assign result_valid    = (state == ST_REPORT);
  assign dbg_state       = state;
endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Two streamers (GAP_CYCLES 0 and 2) run randomized frames side by side,
// each against a cycle-schedule model derived from frame geometry.
module tb_frame_pixel_streamer;
  localparam int W = 4, H = 4, NPIX = W * H;
  localparam int PW = 8, AW = 17, TOUT = 50, N_FRAMES = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input int lane, input string tag,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL lane%0d %s: got %0h expected %0h @%0t", lane, tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int GAP     = (g == 0) ? 0 : 2;
    localparam int STEP    = GAP + 1;
    localparam int C_DRAIN = 3 + (NPIX - 1) * STEP;

    logic rst, frame_req, busy, result_valid, result_face;
    logic result_timeout, result_proto_err, done_flag;
    logic [AW-1:0] base;
    logic [7:0] result_x, result_y, result_scale;
    face_det_pkg::state_t dbg_state;
    logic [PW-1:0] ram [0:(1 << AW) - 1];
    logic [PW-1:0] exp_q [$];

    frame_pixel_streamer_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

    frame_pixel_streamer #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW),
      .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT)
    ) dut (
      .clk(clk), .rst(rst), .frame_req(frame_req), .frame_base_addr(base),
      .busy(busy), .bus(bus), .result_valid(result_valid),
      .result_face(result_face), .result_x(result_x), .result_y(result_y),
      .result_scale(result_scale), .result_timeout(result_timeout),
      .result_proto_err(result_proto_err), .dbg_state(dbg_state)
    );

    // Synchronous frame RAM, one cycle read latency.
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];

    initial begin : drive
      int mode, k_stop, dly, c_r, c_stop, c_last;
      logic hold_req, ff, exp_rd, exp_pv;
      logic [7:0] fx, fy, fs;
      logic [PW-1:0] last_pix, pix;
      logic [AW-1:0] ea;
      logic [26:0] exp_res, act_res;

      done_flag = 1'b0;
      rst = 1'b1; frame_req = 1'b0; base = '0;
      bus.det_done = 1'b0; bus.det_face_detected = 1'b0;
      bus.det_face_x = '0; bus.det_face_y = '0; bus.det_face_scale = '0;
      repeat (3) @(negedge clk);
      act_res = {result_face, result_x, result_y, result_scale, result_timeout, result_proto_err};
      check(g, "rst_busy", busy, 0);
      check(g, "rst_state", dbg_state, face_det_pkg::ST_IDLE);
      check(g, "rst_rd_en", bus.mem_rd_en, 0);
      check(g, "rst_addr", bus.mem_addr, 0);
      check(g, "rst_start", bus.det_start, 0);
      check(g, "rst_pv", bus.pixel_valid, 0);
      check(g, "rst_pix", bus.pixel_out, 0);
      check(g, "rst_rv", result_valid, 0);
      check(g, "rst_result", act_res, 0);
      rst = 1'b0;
      last_pix = '0;
      @(negedge clk);

      for (int f = 0; f < N_FRAMES; f++) begin
        mode = $urandom_range(0, 3);
        k_stop = $urandom_range(0, NPIX - 1);
        dly = $urandom_range(1, TOUT);
        hold_req = 1'($urandom_range(0, 1));
        ff = 1'($urandom_range(0, 1));
        fx = 8'($urandom); fy = 8'($urandom); fs = 8'($urandom);
        if (f != 4) base = AW'($urandom);
        case (f)
          0: begin mode = 0; base = 17'h100; dly = 10; ff = 1; fx = 12; fy = 20; fs = 3; end
          1: mode = 1;
          2: begin mode = 2; k_stop = 5; hold_req = 1'b1; end
          3: begin mode = 3; k_stop = 8; end
          4: begin mode = 0; dly = TOUT; end
          5: base = 17'h1FFF8;
          default: ;
        endcase

        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
          pix = (f == 0) ? PW'(i) : PW'($urandom);
          ram[AW'(base + AW'(i))] = pix;
          exp_q.push_back(pix);
        end

        c_stop = (mode >= 2) ? 3 + k_stop * STEP : 1 << 20;
        if (mode == 0)      c_r = C_DRAIN + dly + 1;
        else if (mode == 1) c_r = C_DRAIN + TOUT + 1;
        else                c_r = c_stop + 1;
        c_last = (mode == 3) ? c_r : c_r + 1;
        case (mode)
          0:       exp_res = {ff, fx, fy, fs, 1'b0, 1'b0};
          1:       exp_res = {1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0};
          default: exp_res = {1'b0, fx, fy, fs, 1'b0, 1'b1};
        endcase
        bus.det_face_detected = ff;
        bus.det_face_x = fx; bus.det_face_y = fy; bus.det_face_scale = fs;
        frame_req = 1'b1;

        for (int c = 1; c <= c_last; c++) begin
          @(negedge clk);
          exp_rd = (c >= 2) && ((c - 2) % STEP == 0) && ((c - 2) / STEP < NPIX) && (c <= c_stop);
          exp_pv = (c >= 3) && ((c - 3) % STEP == 0) && ((c - 3) / STEP < NPIX) && (c <= c_stop);
          act_res = {result_face, result_x, result_y, result_scale, result_timeout, result_proto_err};
          if (mode == 3 && c == c_r) begin
            last_pix = '0;
            check(g, "mid_rst_pv", bus.pixel_valid, 0);
            check(g, "mid_rst_rd_en", bus.mem_rd_en, 0);
            check(g, "mid_rst_busy", busy, 0);
            check(g, "mid_rst_state", dbg_state, face_det_pkg::ST_IDLE);
            check(g, "mid_rst_result", act_res, 0);
            check(g, "mid_rst_pix", bus.pixel_out, 0);
          end else begin
            if (exp_pv) last_pix = exp_q.pop_front();
            check(g, "det_start", bus.det_start, c == 1);
            check(g, "mem_rd_en", bus.mem_rd_en, exp_rd);
            check(g, "pixel_valid", bus.pixel_valid, exp_pv);
            check(g, "pixel_out", bus.pixel_out, last_pix);
            check(g, "busy", busy, c <= c_r);
            check(g, "result_valid", result_valid, c == c_r);
            if (exp_rd) begin
              ea = base + AW'((c - 2) / STEP);
              check(g, "mem_addr", bus.mem_addr, ea);
            end
            if (c >= c_r) check(g, "result", act_res, exp_res);
            if (c == c_r && mode <= 1) check(g, "pixel_count_left", exp_q.size(), 0);
          end
          // Inputs for this cycle, applied away from the rising edge.
          bus.det_done = (mode == 0 && c == C_DRAIN + dly) || (mode == 2 && c == c_stop);
          rst = (mode == 3 && c == c_stop);
          frame_req = hold_req && (c < c_r);
        end
        bus.det_done = 1'b0;
        rst = 1'b0;
      end
      done_flag = 1'b1;
    end
  end

  initial begin : summary
    int waited;
    waited = 0;
    while (!(lane[0].done_flag === 1'b1 && lane[1].done_flag === 1'b1) && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    check(0, "lanes_finished", {lane[0].done_flag, lane[1].done_flag}, 2'b11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
